add_sub_cla_4bit: RTL and testbench



---
 rtl/add_sub_cla_4bit_if.sv | 22 ++
 rtl/add_sub_cla_4bit.sv | 99 +++++++++
 tb/tb_add_sub_cla_4bit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/add_sub_cla_4bit_if.sv
// Operand/result bundle for add_sub_cla_4bit.
// The master drives operands and collects results; the slave is the arithmetic block.
interface add_sub_cla_4bit_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
    logic       in_valid;
    logic [3:0] sum;
    logic       carry;
    logic       overflow;
    logic       out_valid;

    modport master (
        output a, b, sel, in_valid,
        input  sum, carry, overflow, out_valid
    );

    modport slave (
        input  a, b, sel, in_valid,
        output sum, carry, overflow, out_valid
    );
endinterface

// File: rtl/add_sub_cla_4bit.sv
// Registered 4-bit two's-complement adder/subtractor on a carry-lookahead core.
// sel = 0 adds, sel = 1 subtracts (a + ~b + 1). Carries are flat two-level
// sum-of-products so no carry ripples through lower bit positions.
// Build option: define ADDSUB_CLA_INREG_EN to register a, b, sel and in_valid
// ahead of the core (latency 2 instead of 1).
module add_sub_cla_4bit (
    input  logic                   clk,
    input  logic                   rst,
    add_sub_cla_4bit_if.slave      bus
);

    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       op_sel;
    logic       op_vld;

`ifdef ADDSUB_CLA_INREG_EN
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       sel_q;
    logic       vld_q;

    // Input stage: capture operands every cycle, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= 4'd0;
            b_q   <= 4'd0;
            sel_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            sel_q <= bus.sel;
            vld_q <= bus.in_valid;
        end
    end

    assign op_a   = a_q;
    assign op_b   = b_q;
    assign op_sel = sel_q;
    assign op_vld = vld_q;
`else
    assign op_a   = bus.a;
    assign op_b   = bus.b;
    assign op_sel = bus.sel;
    assign op_vld = bus.in_valid;
`endif

    // Operand conditioning: invert b and inject carry-in for subtraction.
    logic [3:0] bx;
    logic [3:0] g;
    logic [3:0] p;
    logic       c0, c1, c2, c3, c4;

    assign bx = op_b ^ {4{op_sel}};
    assign c0 = op_sel;
    assign g  = op_a & bx;
    assign p  = op_a ^ bx;

    // Fully expanded lookahead carries.
    assign c1 = g[0]
              | (p[0] & c0);
    assign c2 = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c0);
    assign c3 = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
    assign c4 = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

    logic [3:0] sum_c;
    logic       ovf_c;

    assign sum_c = p ^ {c3, c2, c1, c0};
    assign ovf_c = c3 ^ c4;

    // Output stage: results load only on valid, out_valid follows valid every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sum       <= 4'd0;
            bus.carry     <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= op_vld;
            if (op_vld) begin
                bus.sum      <= sum_c;
                bus.carry    <= c4;
                bus.overflow <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_add_sub_cla_4bit.sv
// Scoreboard bench for add_sub_cla_4bit. Expected results are queued when an
// operation is issued and compared when out_valid is observed; while no result
// is due the outputs must hold the last result (or 0 after reset).
module tb_add_sub_cla_4bit;

`ifdef ADDSUB_CLA_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [3:0] s;
        logic       c;
        logic       o;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    add_sub_cla_4bit_if bus ();

    add_sub_cla_4bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t held  = '0;
    logic [1:0] vpipe = 2'b00;
    logic rst_q = 1'b1;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic: integer add/sub, unsigned compare for carry,
    // signed range test for overflow.
    function automatic res_t model(input logic [3:0] a, input logic [3:0] b, input logic op);
        res_t r;
        int ua, ub, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = a[3] ? ua - 16 : ua;
        sb = b[3] ? ub - 16 : ub;
        if (op) begin
            r.s = 4'((ua - ub + 16) % 16);
            r.c = (ua >= ub);
            sr  = sa - sb;
        end else begin
            r.s = 4'((ua + ub) % 16);
            r.c = (ua + ub) > 15;
            sr  = sa + sb;
        end
        r.o = (sr < -8) || (sr > 7);
        return r;
    endfunction

    // Track when a result is due; reset discards everything still in flight.
    always @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            vpipe <= 2'b00;
            exp_q.delete();
        end else begin
            vpipe <= {vpipe[0], bus.in_valid};
        end
    end

    // Compare outputs mid-cycle.
    always @(negedge clk) begin
        logic due;
        due = (LAT == 2) ? vpipe[1] : vpipe[0];
        if (rst_q) held = '0;
        chk("out_valid", {7'd0, bus.out_valid}, {7'd0, due});
        if (due) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 8'd1, 8'd0);
            end else begin
                held = exp_q.pop_front();
            end
        end
        chk("sum",      {4'd0, bus.sum},      {4'd0, held.s});
        chk("carry",    {7'd0, bus.carry},    {7'd0, held.c});
        chk("overflow", {7'd0, bus.overflow}, {7'd0, held.o});
    end

    task automatic step(input logic r, input logic v, input logic [3:0] a,
                        input logic [3:0] b, input logic s);
        @(posedge clk);
        #1;
        rst          = r;
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.sel      = s;
        if (v && !r) exp_q.push_back(model(a, b, s));
    endtask

    logic [3:0] va[5] = '{4'h5, 4'h6, 4'h4, 4'hA, 4'h4};
    logic [3:0] vb[5] = '{4'h9, 4'hA, 4'h5, 4'h7, 4'h7};
    logic [3:0] sa[5] = '{4'h5, 4'hA, 4'h4, 4'hA, 4'h4};
    logic [3:0] sb[5] = '{4'h9, 4'h6, 4'h5, 4'h7, 4'h7};

    initial begin
        bus.in_valid = 1'b1;
        bus.a        = 4'($urandom);
        bus.b        = 4'($urandom);
        bus.sel      = 1'b0;
        // Reset with valid operands presented.
        step(1'b1, 1'b1, 4'($urandom), 4'($urandom), 1'b1);
        step(1'b1, 1'b1, 4'($urandom), 4'($urandom), 1'b0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        // Add sequence.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, va[i], vb[i], 1'b0);
        // Subtract sequence.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, sa[i], sb[i], 1'b1);
        // Hold after (A,7) add.
        step(1'b0, 1'b1, 4'hA, 4'h7, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 1'b1);
        // Back-to-back sel toggling.
        step(1'b0, 1'b1, 4'hF, 4'h1, 1'b0);
        step(1'b0, 1'b1, 4'h0, 4'h1, 1'b1);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        // Mid-stream reset during the add sequence.
        for (int i = 0; i < 5; i++) step(i == 2, 1'b1, va[i], vb[i], 1'b0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        // Edge cases: subtract zero, 8 - 8.
        step(1'b0, 1'b1, 4'h9, 4'h0, 1'b1);
        step(1'b0, 1'b1, 4'h8, 4'h8, 1'b1);
        // Random traffic with sparse valid.
        for (int i = 0; i < 60; i++)
            step(1'b0, 1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom));
        for (int i = 0; i < LAT + 2; i++) step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk("drain", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
